// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module : clk_div_pkg
// Brief  : Shared state encoding and limits for the clk_div_ctrl block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

`default_nettype wire

// File: rtl/clk_div_core.sv
// ============================================================================
// Module : clk_div_core
// Brief  : Divide counter with registered clk_out and end-of-period tick.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_div_core #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         load,
    input  logic [W-1:0] div,
    output logic         wrap,
    output logic         clk_out,
    output logic         tick
);

    logic [W-1:0] r_cnt;
    logic         r_clk_out;
    logic         r_tick;
    logic [W-1:0] w_last;
    logic [W-1:0] w_half;
    logic [W-1:0] w_cnt_next;

    assign w_last     = div - W'(1);
    assign w_half     = div >> 1;
    assign wrap       = (r_cnt == w_last);
    assign w_cnt_next = wrap ? '0 : r_cnt + W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (!run) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (load) begin
            // Every legal divisor has a high half of at least one cycle.
            r_cnt     <= '0;
            r_clk_out <= 1'b1;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_clk_out <= (w_cnt_next < w_half);
            r_tick    <= (w_cnt_next == w_last);
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// Module : clk_div_ctrl
// Brief  : Programmable clock divider with glitch-free start/stop and divisor
//          changes deferred to period boundaries. Optional period counter
//          enabled by defining CLK_DIV_CTRL_PERIOD_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int W           = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         en,
    input  logic         div_valid,
    input  logic [W-1:0] div_value,
    output logic         div_ready,
    output logic         clk_out,
    output logic         tick,
    output logic         busy,
    output logic         err,
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    output logic [15:0]  period_cnt,
`endif
    output logic [W-1:0] cur_div
);

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_cur_div;
    logic [W-1:0] r_pend_div;
    logic         r_pend_valid;
    logic         r_err;
    logic         w_wrap_raw;
    logic         w_wrap;
    logic         w_xfer;
    logic         w_bad;
    logic         w_apply;
    logic         w_start;
    logic         w_run;

    assign w_xfer  = div_valid & ~r_pend_valid;
    assign w_bad   = (div_value < W'(MIN_DIV));
    assign w_wrap  = (r_state != OFF) & w_wrap_raw;
    // The pending flag is sampled before this edge, so a value captured on a
    // wrap edge waits for the next wrap.
    assign w_apply = w_wrap & r_pend_valid;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) r_state <= OFF;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_run        = 1'b0;
        case (r_state)
            OFF: begin
                if (en) begin
                    w_state_next = RUN;
                    w_start      = 1'b1;
                    w_run        = 1'b1;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (!en) w_state_next = STOPPING;
            end
            STOPPING: begin
                if (en) begin
                    w_state_next = RUN;
                    w_run        = 1'b1;
                end else if (w_wrap) begin
                    w_state_next = OFF;
                end else begin
                    w_run = 1'b1;
                end
            end
            default: w_state_next = OFF;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_div    <= W'(DEFAULT_DIV);
            r_pend_div   <= '0;
            r_pend_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= w_xfer & w_bad;
            if (w_apply) begin
                r_cur_div    <= r_pend_div;
                r_pend_valid <= 1'b0;
            end
            if (w_xfer && !w_bad) begin
                if (r_state == OFF) begin
                    r_cur_div <= div_value;
                end else begin
                    r_pend_div   <= div_value;
                    r_pend_valid <= 1'b1;
                end
            end
        end
    end

    clk_div_core #(
        .W (W)
    ) u_core (
        .clk     (clk_in),
        .rst_n   (rst_n),
        .run     (w_run),
        .load    (w_start | w_apply),
        .div     (r_cur_div),
        .wrap    (w_wrap_raw),
        .clk_out (clk_out),
        .tick    (tick)
    );

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0] r_period_cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)       r_period_cnt <= '0;
        else if (w_start) r_period_cnt <= '0;
        else if (tick)    r_period_cnt <= r_period_cnt + 16'd1;
    end

    assign period_cnt = r_period_cnt;
`endif

    assign div_ready = ~r_pend_valid;
    assign busy      = (r_state != OFF);
    assign err       = r_err;
    assign cur_div   = r_cur_div;

endmodule

`default_nettype wire

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Runtime-programmable clock divider controller with glitch-free start/stop and deferred divisor reconfiguration.
- Owns the divide counter and the registered clk_out/tick generation.
- Sequences enable/disable and divisor changes so they take effect only at output-period boundaries.
- Sits between a register/config master (valid/ready handshake) and downstream logic clocked or enabled by clk_out/tick.

Parameters:
W, 16, width of the divisor value and internal counter
DEFAULT_DIV, 10, active divisor after reset (must be >= 2)

Ports:
clk_in  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  level enable; 1 = run divider, 0 = stop at next period boundary
div_valid  input  1  new divisor offered
div_value  input  W  requested divisor N
div_ready  output  1  controller can accept a divisor
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle strobe on the last cycle of each output period
busy  output  1  state != OFF
err  output  1  one-cycle pulse: rejected divisor (N < 2)
cur_div  output  W  divisor currently in effect

Behaviour:
- Reset (async, rst_n=0): state OFF, cnt=0, cur_div=DEFAULT_DIV, pending flag=0, clk_out=0, tick=0, busy=0, err=0, div_ready=1. Reset mid-operation clears immediately with no graceful stop.
- States: OFF, RUN, STOPPING. busy=1 in RUN and STOPPING.
- OFF: clk_out=0, cnt=0, tick=0.
  - Edge with en=1: go to RUN, cnt<=0, clk_out<=1. clk_out rises one cycle after en is sampled.
- RUN/STOPPING counting (N=cur_div, H=N>>1):
  - cnt_next = (cnt==N-1) ? 0 : cnt+1.
  - clk_out <= (cnt_next < H).
  - N=10: 5 cycles high, 5 low. N=5: 2 high, 3 low. N=2: 1 high, 1 low.
  - tick <= (cnt_next==N-1), so tick is high during the last low cycle of each period.
  - "Wrap" is the edge where cnt==N-1.
- RUN with en=0 sampled: go to STOPPING and keep counting. At wrap, go to OFF; clk_out stays 0 with no runt pulse.
- STOPPING with en=1 sampled: return to RUN without disturbing cnt/clk_out.
- Divisor handshake: transfer occurs when div_valid & div_ready at an edge.
  - div_value < 2: discard; err=1 for one cycle; cur_div unchanged; div_ready stays 1.
  - OFF: cur_div <= div_value at the same edge; div_ready stays 1.
  - RUN/STOPPING: store in pending and drop div_ready. At the next wrap, cur_div <= pending, cnt <= 0, clk_out <= (0 < H_new), pending cleared, div_ready=1 from the following cycle.
  - A transfer on the same edge as a wrap is applied at the following wrap, not this one.
- STOPPING→OFF with a pending update: cur_div is updated at that wrap.
- Changes to div_value while div_ready=0 are ignored. At most one pending value exists.
- Counter compares use W-bit unsigned arithmetic. N = 2^W-1 is legal.

Optional Feature:
Macro CLK_DIV_CTRL_PERIOD_CNT_EN.
- Defined: extra output period_cnt [15:0], increments on every tick, wraps at 16'hFFFF→0, cleared on reset and on OFF→RUN.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package clk_div_pkg: state enum (OFF, RUN, STOPPING) and constant MIN_DIV=2.
- Sub-module clk_div_core: cnt, clk_out and tick generation from cur_div, a load strobe and a run enable.
- clk_div_ctrl: FSM, handshake, pending register and err.

Test Plan:
- Reset release, en=1 with DEFAULT_DIV=10, 1 kHz clk_in → clk_out 100 Hz (5 high/5 low); tick once per 10 cycles, coinciding with the last low cycle.
- In RUN at N=10, offer div_value=4 mid-period → div_ready low until wrap; first new period 2 high/2 low; cur_div=4; no period shorter than 2 cycles.
- Offer div_value=1 and div_value=0 → err pulses one cycle each; cur_div and clk_out unaffected.
- Deassert en at cnt=2 (N=10) → clk_out completes the period, goes OFF at wrap with busy=0; reassert en during STOPPING → no gap in clk_out.
- N=5 and N=2 → duty 2/3 and 1/1; tick every 5 and 2 cycles respectively.
- Assert rst_n=0 mid-period, then handshake on a wrap edge → outputs clear immediately; value accepted at the wrap applies one period later. With CLK_DIV_CTRL_PERIOD_CNT_EN defined, period_cnt=6 after 6 ticks.
